lsu_mem: RTL and testbench

//  Consumer of agu results: takes one issued load/store (address, shifted wdata, byte mask) and

---
 rtl/lsu_mem.sv | 198 +++++++++++++++++++
 tb/tb_lsu_mem.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// ============================================================================
// lsu_mem : load/store unit memory stage -- one op in flight on the dmem port,
//           load alignment/extension, EBR clean/kill. Optional: LSU_MEM_BYPASS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

package backend_types;
    localparam int BR_TAGS  = 4;
    localparam int BR_TAG_W = 2;

    typedef struct packed {
        logic [BR_TAGS-1:0] branch_mask;
        logic [4:0]         rd;
        logic [5:0]         rob_idx;
    } meta_t;

    typedef struct packed {
        meta_t       meta;
        logic [31:0] pc;
    } issue_stage_t;

    typedef struct packed {
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_mask;
    } agu_result_t;
endpackage

interface brb_itf;
    import backend_types::*;
    logic                broadcast;
    logic [BR_TAG_W-1:0] tag;
    logic                clean;
    logic                kill;
    modport req (input broadcast, tag, clean, kill);
    modport drv (output broadcast, tag, clean, kill);
endinterface

module lsu_mem
    import backend_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    brb_itf.req          brif,
    input  issue_stage_t istage,
    input  agu_result_t  iresult,
    input  logic [2:0]   mem_op,
    input  logic         is_store,
    input  logic         ivalid,
    output logic         iready,
    output logic [31:0]  dmem_addr,
    output logic [3:0]   dmem_rmask,
    output logic [3:0]   dmem_wmask,
    output logic [31:0]  dmem_wdata,
    input  logic [31:0]  dmem_rdata,
    input  logic         dmem_resp,
    output issue_stage_t ostage,
    output logic [31:0]  ordata,
    output logic         ovalid,
    input  logic         oready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t       state_q, state_d;
    issue_stage_t stage_q, stage_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  ordata_q, ordata_d;
    logic [3:0]   mask_q, mask_d;
    logic [2:0]   op_q, op_d;
    logic         store_q, store_d;

    logic         in_hit, held_hit, held_kill, held_clean, accept, req_active;
    issue_stage_t in_stage;
    logic [31:0]  shifted, load_data;

    // Branch-bus decode for both the incoming op and the held op
    always_comb begin
        in_hit     = brif.broadcast & istage.meta.branch_mask[brif.tag];
        held_hit   = brif.broadcast & stage_q.meta.branch_mask[brif.tag];
        held_kill  = held_hit & brif.kill;
        held_clean = held_hit & brif.clean;
        in_stage   = istage;
        if (in_hit && brif.clean) begin
            in_stage.meta.branch_mask[brif.tag] = 1'b0;
        end
    end

`ifdef LSU_MEM_BYPASS_EN
    assign iready = (state_q == S_IDLE) | ((state_q == S_DONE) & oready & ~held_kill);
`else
    assign iready = (state_q == S_IDLE);
`endif
    assign accept = ivalid & iready & ~(in_hit & brif.kill);

    always_comb begin
        shifted   = dmem_rdata >> {addr_q[1:0], 3'b000};
        load_data = shifted;
        case (op_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        op_d     = op_q;
        store_d  = store_q;
        ordata_d = ordata_q;

        if (state_q != S_IDLE && held_clean) begin
            stage_d.meta.branch_mask[brif.tag] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_REQ;
            end
            S_REQ: begin
                // A kill coinciding with resp consumes the resp: nothing left to drain
                if (held_kill) begin
                    state_d = dmem_resp ? S_IDLE : S_DRAIN;
                end else if (dmem_resp) begin
                    state_d  = S_DONE;
                    ordata_d = store_q ? 32'h0 : load_data;
                end
            end
            S_DRAIN: begin
                if (dmem_resp) state_d = S_IDLE;
            end
            S_DONE: begin
                if (held_kill) begin
                    state_d = S_IDLE;
                end else if (oready) begin
                    state_d = accept ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            stage_d = in_stage;
            addr_d  = iresult.mem_addr;
            wdata_d = iresult.mem_wdata;
            mask_d  = iresult.mem_mask;
            op_d    = mem_op;
            store_d = is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            mask_q   <= 4'h0;
            op_q     <= 3'b000;
            store_q  <= 1'b0;
            ordata_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            op_q     <= op_d;
            store_q  <= store_d;
            ordata_q <= ordata_d;
        end
    end

    assign req_active = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_rmask = (req_active && !store_q) ? mask_q : 4'h0;
    assign dmem_wmask = (req_active &&  store_q) ? mask_q : 4'h0;
    assign dmem_wdata = wdata_q;
    assign ostage     = stage_q;
    assign ordata     = ordata_q;
    assign ovalid     = (state_q == S_DONE) & ~held_kill;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem.sv
// ============================================================================
// tb_lsu_mem : scenario tasks plus a result scoreboard for lsu_mem
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem;
    import backend_types::*;

    logic         clk = 1'b0;
    logic         rst_n;
    issue_stage_t istage;
    agu_result_t  iresult;
    logic [2:0]   mem_op;
    logic         is_store, ivalid, iready;
    logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]   dmem_rmask, dmem_wmask;
    logic         dmem_resp;
    issue_stage_t ostage;
    logic [31:0]  ordata;
    logic         ovalid, oready;

    brb_itf brb();

    typedef struct packed {
        logic [31:0]  data;
        issue_stage_t stage;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lsu_mem dut (
        .clk(clk), .rst_n(rst_n), .brif(brb),
        .istage(istage), .iresult(iresult), .mem_op(mem_op), .is_store(is_store),
        .ivalid(ivalid), .iready(iready),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .ostage(ostage), .ordata(ordata), .ovalid(ovalid), .oready(oready)
    );

    // Scoreboard: a handshake is predicted for the coming edge, inputs being stable until next negedge
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && ovalid === 1'b1 && oready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: ovalid=1 ordata=%h, required no result", ordata);
            end else begin
                mon_e = sb_q.pop_front();
                if (ordata !== mon_e.data || ostage !== mon_e.stage) begin
                    failures++;
                    $display("FAIL sb_result: ordata=%h ostage=%h, required ordata=%h ostage=%h",
                             ordata, ostage, mon_e.data, mon_e.stage);
                end
            end
        end
    end

    function automatic issue_stage_t mk_stage(input logic [3:0] bm, input logic [5:0] rob);
        issue_stage_t s;
        s                  = '0;
        s.meta.branch_mask = bm;
        s.meta.rd          = rob[4:0];
        s.meta.rob_idx     = rob;
        s.pc               = 32'h8000_0000 | {24'h0, rob, 2'b00};
        return s;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus(input logic bc, input logic [1:0] tag, input logic cl, input logic kl);
        brb.broadcast = bc;
        brb.tag       = tag;
        brb.clean     = cl;
        brb.kill      = kl;
    endtask

    task automatic present(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                           input logic [2:0] op, input logic st, input issue_stage_t stg);
        iresult.mem_addr  = addr;
        iresult.mem_wdata = wdata;
        iresult.mem_mask  = mask;
        mem_op            = op;
        is_store          = st;
        istage            = stg;
        ivalid            = 1'b1;
    endtask

    // Single op with oready=1; masks must be held for 'hold' cycles, resp on the last one
    task automatic do_op(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic [2:0] op, input logic st,
                         input issue_stage_t stg, input int hold, input logic [31:0] rdata,
                         input logic [31:0] exp_data);
        logic [3:0] er, ew;
        er = st ? 4'h0 : mask;
        ew = st ? mask : 4'h0;
        sb_q.push_back({exp_data, stg});
        present(addr, wdata, mask, op, st, stg);
        #1;
        checks++;
        if (iready !== 1'b1) begin
            failures++;
            $display("FAIL %s_iready: iready=%b, required 1", name, iready);
        end
        tick();
        ivalid = 1'b0;
        for (int c = 1; c <= hold; c++) begin
            dmem_rdata = $urandom;
            if (c == hold) begin
                dmem_resp  = 1'b1;
                dmem_rdata = rdata;
            end
            #1;
            checks++;
            if (dmem_rmask !== er || dmem_wmask !== ew || dmem_addr !== {addr[31:2], 2'b00} ||
                ovalid !== 1'b0 || (st && dmem_wdata !== wdata)) begin
                failures++;
                $display("FAIL %s_hold c=%0d: rmask=%b wmask=%b addr=%h wdata=%h ovalid=%b, required rmask=%b wmask=%b addr=%h wdata=%h ovalid=0",
                         name, c, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata, ovalid,
                         er, ew, {addr[31:2], 2'b00}, wdata);
            end
            tick();
            dmem_resp = 1'b0;
        end
        #1;
        checks++;
        if (ovalid !== 1'b1 || dmem_rmask !== 4'h0 || dmem_wmask !== 4'h0) begin
            failures++;
            $display("FAIL %s_done: ovalid=%b rmask=%b wmask=%b, required 1 0000 0000",
                     name, ovalid, dmem_rmask, dmem_wmask);
        end
        tick();
        #1;
        checks++;
        if (ovalid !== 1'b0 || iready !== 1'b1) begin
            failures++;
            $display("FAIL %s_retire: ovalid=%b iready=%b, required 0 1", name, ovalid, iready);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #1;
        checks++;
        if (ovalid !== 1'b0 || dmem_rmask !== 4'h0 || dmem_wmask !== 4'h0) begin
            failures++;
            $display("FAIL reset_ctrl: ovalid=%b rmask=%b wmask=%b, required 0 0000 0000",
                     ovalid, dmem_rmask, dmem_wmask);
        end
        checks++;
        if (ordata !== 32'h0 || ostage !== '0 || iready !== 1'b1) begin
            failures++;
            $display("FAIL reset_data: ordata=%h ostage=%h iready=%b, required 0 0 1", ordata, ostage, iready);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_ext();
        do_op("lb",  32'h0000_1003, 32'h0, 4'b1000, 3'b000, 1'b0, mk_stage(4'b0001, 6'd1), 1,
              32'h80AA_5511, 32'hFFFF_FF80);
        do_op("lhu", 32'h0000_2002, 32'h0, 4'b1100, 3'b101, 1'b0, mk_stage(4'b0000, 6'd2), 1,
              32'hBEEF_1234, 32'h0000_BEEF);
        do_op("lh",  32'h0000_1000, 32'h0, 4'b0011, 3'b001, 1'b0, mk_stage(4'b0000, 6'd9), 2,
              32'h1234_8001, 32'hFFFF_8001);
        do_op("lbu", 32'h0000_5001, 32'h0, 4'b0010, 3'b100, 1'b0, mk_stage(4'b0000, 6'd10), 1,
              32'h0000_F000, 32'h0000_00F0);
        do_op("lw",  32'h0000_0044, 32'h0, 4'b1111, 3'b010, 1'b0, mk_stage(4'b0000, 6'd11), 1,
              32'h89AB_CDEF, 32'h89AB_CDEF);
    endtask

    task automatic test_store();
        do_op("sw", 32'h0000_0030, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b1, mk_stage(4'b0000, 6'd12), 5,
              32'h1234_5678, 32'h0);
    endtask

    task automatic test_accept_kill();
        present(32'h100, 32'h0, 4'hF, 3'b010, 1'b0, mk_stage(4'b0010, 6'd13));
        bus(1'b1, 2'd1, 1'b0, 1'b1);
        tick();
        ivalid = 1'b0;
        bus(1'b0, 2'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (dmem_rmask !== 4'h0 || iready !== 1'b1 || ovalid !== 1'b0) begin
            failures++;
            $display("FAIL accept_kill: rmask=%b iready=%b ovalid=%b, required 0000 1 0",
                     dmem_rmask, iready, ovalid);
        end
    endtask

    task automatic test_kill_req();
        present(32'h400, 32'h0, 4'hF, 3'b010, 1'b0, mk_stage(4'b0100, 6'd3));
        tick();
        ivalid = 1'b0;
        bus(1'b1, 2'd2, 1'b0, 1'b1);
        tick();
        bus(1'b0, 2'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                dmem_resp  = 1'b1;
                dmem_rdata = 32'hCAFE_F00D;
            end
            #1;
            checks++;
            if (dmem_rmask !== 4'hF || ovalid !== 1'b0 || iready !== 1'b0) begin
                failures++;
                $display("FAIL kill_req_drain c=%0d: rmask=%b ovalid=%b iready=%b, required 1111 0 0",
                         c, dmem_rmask, ovalid, iready);
            end
            tick();
            dmem_resp = 1'b0;
        end
        #1;
        checks++;
        if (dmem_rmask !== 4'h0 || ovalid !== 1'b0 || iready !== 1'b1) begin
            failures++;
            $display("FAIL kill_req_end: rmask=%b ovalid=%b iready=%b, required 0000 0 1",
                     dmem_rmask, ovalid, iready);
        end
    endtask

    task automatic test_kill_resp_same();
        present(32'h500, 32'h0, 4'hF, 3'b010, 1'b0, mk_stage(4'b1000, 6'd4));
        tick();
        ivalid     = 1'b0;
        bus(1'b1, 2'd3, 1'b0, 1'b1);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        tick();
        bus(1'b0, 2'd0, 1'b0, 1'b0);
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (dmem_rmask !== 4'h0 || ovalid !== 1'b0 || iready !== 1'b1) begin
            failures++;
            $display("FAIL kill_resp_same: rmask=%b ovalid=%b iready=%b, required 0000 0 1",
                     dmem_rmask, ovalid, iready);
        end
    endtask

    task automatic test_clean_done();
        issue_stage_t stg, exp_stg;
        stg                      = mk_stage(4'b0110, 6'd5);
        exp_stg                  = stg;
        exp_stg.meta.branch_mask = 4'b0100;
        sb_q.push_back({32'h0000_00AA, exp_stg});
        oready = 1'b0;
        present(32'h600, 32'h0, 4'b0001, 3'b100, 1'b0, stg);
        tick();
        ivalid     = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h0000_00AA;
        tick();
        dmem_resp = 1'b0;
        bus(1'b1, 2'd1, 1'b1, 1'b0);
        #1;
        checks++;
        if (ovalid !== 1'b1) begin
            failures++;
            $display("FAIL clean_done_valid: ovalid=%b, required 1", ovalid);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            // a kill on a tag the op does not depend on must be ignored
            if (i == 1) bus(1'b1, 2'd0, 1'b0, 1'b1);
            else        bus(1'b0, 2'd0, 1'b0, 1'b0);
            #1;
            checks++;
            if (ovalid !== 1'b1 || ostage.meta.branch_mask !== 4'b0100) begin
                failures++;
                $display("FAIL clean_done_hold i=%0d: ovalid=%b mask=%b, required 1 0100",
                         i, ovalid, ostage.meta.branch_mask);
            end
            tick();
        end
        bus(1'b0, 2'd0, 1'b0, 1'b0);
        oready = 1'b1;
        tick();
        #1;
        checks++;
        if (ovalid !== 1'b0 || iready !== 1'b1) begin
            failures++;
            $display("FAIL clean_done_retire: ovalid=%b iready=%b, required 0 1", ovalid, iready);
        end
    endtask

    task automatic test_kill_done();
        oready = 1'b0;
        present(32'h700, 32'h0, 4'hF, 3'b010, 1'b0, mk_stage(4'b0001, 6'd6));
        tick();
        ivalid     = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h7777_0000;
        tick();
        dmem_resp = 1'b0;
        tick();
        bus(1'b1, 2'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (ovalid !== 1'b0) begin
            failures++;
            $display("FAIL kill_done_now: ovalid=%b, required 0", ovalid);
        end
        tick();
        bus(1'b0, 2'd0, 1'b0, 1'b0);
        oready = 1'b1;
        #1;
        checks++;
        if (ovalid !== 1'b0 || iready !== 1'b1) begin
            failures++;
            $display("FAIL kill_done_idle: ovalid=%b iready=%b, required 0 1", ovalid, iready);
        end
    endtask

    task automatic test_back_to_back();
        issue_stage_t sa, sb;
        sa = mk_stage(4'b0000, 6'd7);
        sb = mk_stage(4'b0000, 6'd8);
        sb_q.push_back({32'h1111_2222, sa});
        sb_q.push_back({32'h3333_4444, sb});
        oready = 1'b1;
        present(32'h40, 32'h0, 4'hF, 3'b010, 1'b0, sa);
        tick();
        ivalid     = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h1111_2222;
        tick();
        dmem_resp = 1'b0;
        present(32'h48, 32'h0, 4'hF, 3'b010, 1'b0, sb);
        #1;
        checks++;
`ifdef LSU_MEM_BYPASS_EN
        if (iready !== 1'b1 || ovalid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_bypass: iready=%b ovalid=%b, required 1 1", iready, ovalid);
        end
        tick();
`else
        if (iready !== 1'b0 || ovalid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap_done: iready=%b ovalid=%b, required 0 1", iready, ovalid);
        end
        tick();
        #1;
        checks++;
        if (iready !== 1'b1 || ovalid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap_idle: iready=%b ovalid=%b, required 1 0", iready, ovalid);
        end
        tick();
`endif
        ivalid = 1'b0;
        #1;
        checks++;
        if (dmem_rmask !== 4'hF || dmem_addr !== 32'h48) begin
            failures++;
            $display("FAIL b2b_second_req: rmask=%b addr=%h, required 1111 00000048", dmem_rmask, dmem_addr);
        end
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h3333_4444;
        tick();
        dmem_resp = 1'b0;
        #1;
        checks++;
        if (ovalid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_done: ovalid=%b, required 1", ovalid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        present(32'h80, 32'h0BAD_F00D, 4'hF, 3'b010, 1'b1, mk_stage(4'b0011, 6'd14));
        tick();
        ivalid = 1'b0;
        #1;
        checks++;
        if (dmem_wmask !== 4'hF) begin
            failures++;
            $display("FAIL reset_mid_pre: wmask=%b, required 1111", dmem_wmask);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_wmask !== 4'h0 || dmem_rmask !== 4'h0 || ovalid !== 1'b0 || iready !== 1'b1 ||
            ostage !== '0 || ordata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: wmask=%b rmask=%b ovalid=%b iready=%b ostage=%h ordata=%h, required 0000 0000 0 1 0 0",
                     dmem_wmask, dmem_rmask, ovalid, iready, ostage, ordata);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        ivalid     = 1'b0;
        istage     = '0;
        iresult    = '0;
        mem_op     = 3'b000;
        is_store   = 1'b0;
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        oready     = 1'b1;
        bus(1'b0, 2'd0, 1'b0, 1'b0);

        test_reset();
        test_load_ext();
        test_store();
        test_accept_kill();
        test_kill_req();
        test_kill_resp_same();
        test_clean_done();
        test_kill_done();
        test_back_to_back();
        test_reset_mid();

        tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: pending=%0d, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
